wptr_full_ctrl: RTL and testbench
=================================

# wptr_full_ctrl

Write-side pointer and full-flag controller for the dual-clock FIFO. It sits directly upstream of the FIFO memory in the write clock domain and drives that memory's write address, write enable and full inputs. It owns the binary/Gray write pointer, synchronizes the read-domain Gray pointer, and generates a registered full flag plus a sticky overflow flag. An optional fill-level/almost-full status path is available.

## Interface
Parameters:
- ADDRWIDTH, 4: memory address width; DEPTH = 2**ADDRWIDTH; legal range ≥ 2.
- AFULL_LEVEL, 14: almost-full threshold in entries, 1..DEPTH; used only with the status feature.

Ports:
- wclk  in  1  write-domain clock; all state changes on the rising edge.
- wrst  in  1  reset; synchronous to wclk, active-high.
- winc  in  1  write request for the current cycle.
- rptr  in  ADDRWIDTH+1  read-domain Gray pointer; asynchronous to wclk.
- woverflow_clr  in  1  clears woverflow.
- waddr  out  ADDRWIDTH  memory write address; low bits of the binary write pointer.
- wclken  out  1  memory write enable; equals winc.
- wfull  out  1  registered full flag; also drives the memory wfull input.
- wptr  out  ADDRWIDTH+1  registered Gray write pointer, sent to the read domain.
- woverflow  out  1  sticky flag: a write was attempted while full.
- wlevel  out  ADDRWIDTH+1  registered conservative fill level.
- walmost_full  out  1  registered flag: wlevel ≥ AFULL_LEVEL.

## Operation
- Write acceptance: a write is accepted when winc && !wfull. On an accepted write, wbin increments modulo 2*DEPTH and wptr becomes the Gray code of the new wbin.
- Memory interface: waddr = wbin[ADDRWIDTH-1:0]. The memory uses its own wfull gating; this block does not re-gate wclken.
- Synchronizer: rptr passes through two wclk flops (rq1, rq2). Only rq2 is used for comparison.
- Full logic:
  - wgraynext = gray(wbin + accepted).
  - wfull_next = (wgraynext == {~rq2[A:A-1], rq2[A-2:0]}), where A = ADDRWIDTH.
  - wfull is registered from wfull_next.
- Overflow:
  - winc && wfull sets woverflow.
  - woverflow_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- Level: wlevel_next = (wbin + accepted) − gray2bin(rq2), computed modulo 2*DEPTH, width A+1, registered. The value is pessimistic because rq2 lags the true read pointer. Range is 0..DEPTH.
- walmost_full: registered from wlevel_next ≥ AFULL_LEVEL.
- Wrap-around: wbin rolls from 2*DEPTH−1 to 0 with no special handling. wptr changes exactly one bit per accepted write, including at the wrap.
- Reset: wrst has priority over all other inputs.

## Timing
- Reset values: wbin = 0, wptr = 0, rq1 = rq2 = 0, waddr = 0, wfull = 0, woverflow = 0, wlevel = 0, walmost_full = 0. wclken follows winc combinationally.
- Accepted write at edge N:
  - waddr and wptr update at edge N.
  - wfull, wlevel and walmost_full reflect that write from edge N.
- Read-pointer latency: after rptr changes and is stable, rq2 updates at the 2nd wclk edge. wfull, wlevel and walmost_full reflect the change at the 3rd edge.
- Write while full (winc = 1, wfull = 1):
  - The write is not accepted; wbin and wptr hold.
  - woverflow = 1 from the next edge.
- Full reached: after the DEPTH-th accepted write with no reads, wfull = 1 from that same edge. No further write is accepted until a rptr advance propagates through the synchronizer.
- Simultaneous accepted write and rptr advance: both are reflected in the same cycle's wfull_next/level computation once rq2 updates. No write is lost.

## Configuration
- Macro: WPTR_FULL_STATUS_EN.
- Defined: wlevel and walmost_full are implemented as specified above.
- Undefined:
  - wlevel and walmost_full are tied to 0.
  - The level subtractor, the gray2bin logic and the associated registers are not built.
  - Full, overflow and pointer behaviour are identical in both builds.

## Test plan
- Reset: hold wrst for 3 cycles with winc = 1 → all outputs at reset values, waddr = 0, no pointer movement. Release wrst → first write goes to waddr = 0.
- Fill: rptr = 0, apply 16 consecutive winc cycles (ADDRWIDTH = 4) → waddr sequence 0..15, wptr Gray 1,3,2,…,24. wfull = 1 at the edge of the 16th write.
- Overflow: with the FIFO full, winc = 1 for 2 cycles → wptr holds at 5'b11000, woverflow = 1. Pulse woverflow_clr together with winc → woverflow stays 1. Pulse woverflow_clr alone → woverflow = 0.
- Drain release: with the FIFO full, step rptr from 0 to Gray 1 → wfull = 0 at the 3rd wclk edge. The next winc writes waddr = 0.
- Wrap: 40 writes, with rptr following wptr delayed by 4 cycles → wptr changes exactly one bit per accepted write, wbin wraps 31 → 0, wfull is never asserted.
- Status (macro defined, AFULL_LEVEL = 14): rptr = 0, 13 writes → wlevel = 13, walmost_full = 0. 14th write → wlevel = 14, walmost_full = 1. Same test without the macro → wlevel = 0 and walmost_full = 0 throughout.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/full controller for the dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchronizer, registered full and sticky overflow. Optional level path: WPTR_FULL_STATUS_EN.
module wptr_full_ctrl #(
  parameter int ADDRWIDTH   = 4,
  parameter int AFULL_LEVEL = 14
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [ADDRWIDTH:0]   rptr,
  input  logic                 woverflow_clr,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic                 wclken,
  output logic                 wfull,
  output logic [ADDRWIDTH:0]   wptr,
  output logic                 woverflow,
  output logic [ADDRWIDTH:0]   wlevel,
  output logic                 walmost_full
);
  localparam int A = ADDRWIDTH;

  logic [A:0] wbin_reg, wbin_next, wgray_next;
  logic [A:0] wptr_reg, rq1_reg, rq2_reg;
  logic       wfull_reg, wfull_next, woverflow_reg, accepted;

  assign accepted   = winc & ~wfull_reg;
  assign wbin_next  = wbin_reg + {{A{1'b0}}, accepted};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  // Full when the next write pointer has lapped the synchronized read pointer by exactly one pass.
  assign wfull_next = (wgray_next == {~rq2_reg[A:A-1], rq2_reg[A-2:0]});

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_reg      <= '0;
      wptr_reg      <= '0;
      rq1_reg       <= '0;
      rq2_reg       <= '0;
      wfull_reg     <= 1'b0;
      woverflow_reg <= 1'b0;
    end else begin
      wbin_reg  <= wbin_next;
      wptr_reg  <= wgray_next;
      rq1_reg   <= rptr;
      rq2_reg   <= rq1_reg;
      wfull_reg <= wfull_next;
      if (winc && wfull_reg)
        woverflow_reg <= 1'b1;
      else if (woverflow_clr)
        woverflow_reg <= 1'b0;
    end
  end

  assign waddr     = wbin_reg[A-1:0];
  assign wclken    = winc;
  assign wfull     = wfull_reg;
  assign wptr      = wptr_reg;
  assign woverflow = woverflow_reg;

`ifdef WPTR_FULL_STATUS_EN
  logic [A:0] rbin;
  logic [A:0] wlevel_reg, wlevel_next;
  logic       walmost_full_reg, walmost_full_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= A; gi++) begin : g_gray2bin
    assign rbin[gi] = ^rq2_reg[A:gi];
  end

  assign wlevel_next       = wbin_next - rbin;
  assign walmost_full_next = (wlevel_next >= (A+1)'(AFULL_LEVEL));

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wlevel_reg       <= '0;
      walmost_full_reg <= 1'b0;
    end else begin
      wlevel_reg       <= wlevel_next;
      walmost_full_reg <= walmost_full_next;
    end
  end

  assign wlevel       = wlevel_reg;
  assign walmost_full = walmost_full_reg;
`else
  assign wlevel       = '0;
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl: directed vector table, wrap sequence, and
// randomized traffic against a count-based reference model.
module tb_wptr_full_ctrl;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int AF = 14;

  logic          wclk = 1'b0;
  logic          wrst, winc, woverflow_clr;
  logic [AW:0]   rptr;
  logic [AW-1:0] waddr;
  logic          wclken, wfull, woverflow, walmost_full;
  logic [AW:0]   wptr, wlevel;

  int errs = 0;
  int checks = 0;

  wptr_full_ctrl #(.ADDRWIDTH(AW), .AFULL_LEVEL(AF)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr), .woverflow_clr(woverflow_clr),
    .waddr(waddr), .wclken(wclken), .wfull(wfull), .wptr(wptr), .woverflow(woverflow),
    .wlevel(wlevel), .walmost_full(walmost_full)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic rst, inc, clr;
    logic [AW:0] rp;
    logic [AW-1:0] addr;
    logic [AW:0] ptr;
    logic full, ovf;
    logic [AW:0] lvl;
    logic af;
  } vec_t;

  vec_t tbl[27];

  function automatic logic [AW:0] gray(int x);
    logic [AW:0] v;
    v = x[AW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int g2b(logic [AW:0] g);
    int b = 0;
    for (int i = AW; i >= 0; i--) b = (b << 1) | (int'(g[i]) ^ (b & 1));
    return b;
  endfunction

  function automatic vec_t mk(logic rst, logic inc, logic clr, int rp, int addr, int ptr,
                              logic full, logic ovf, int lvl);
    vec_t v;
    v.rst = rst; v.inc = inc; v.clr = clr; v.rp = rp[AW:0];
    v.addr = addr[AW-1:0]; v.ptr = ptr[AW:0]; v.full = full; v.ovf = ovf;
    v.lvl = lvl[AW:0]; v.af = (lvl >= AF);
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(string tag, int lvl, logic af);
`ifdef WPTR_FULL_STATUS_EN
    chk({tag, " wlevel"}, int'(wlevel), lvl);
    chk({tag, " walmost_full"}, int'(walmost_full), int'(af));
`else
    chk({tag, " wlevel"}, int'(wlevel), 0);
    chk({tag, " walmost_full"}, int'(walmost_full), 0);
`endif
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Reference model: counts writes and derives everything from fill arithmetic.
  int          m_wtot, m_lvl;
  logic [AW:0] m_rq1, m_rq2;
  logic        m_full, m_ovf;

  task automatic model_step(logic rst, logic inc, logic clr, logic [AW:0] rp);
    if (rst) begin
      m_wtot = 0; m_lvl = 0; m_rq1 = '0; m_rq2 = '0; m_full = 0; m_ovf = 0;
    end else begin
      if (inc && m_full) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (inc && !m_full) m_wtot++;
      m_lvl  = (((m_wtot - g2b(m_rq2)) % (2*D)) + 2*D) % (2*D);
      m_full = (m_lvl == D);
      m_rq2  = m_rq1;
      m_rq1  = rp;
    end
  endtask

  initial begin
    vec_t t;
    logic [AW:0] prev;
    logic [AW:0] hist[64];
    int rtot;

    // Directed table: reset with winc held, fill, overflow, clear, drain release.
    for (int i = 0; i < 3; i++) tbl[i] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) tbl[2+k] = mk(0, 1, 0, 0, k % D, int'(gray(k)), k == 16, 0, k);
    tbl[19] = mk(0, 1, 0, 0, 0, 24, 1, 1, 16);
    tbl[20] = mk(0, 1, 0, 0, 0, 24, 1, 1, 16);
    tbl[21] = mk(0, 1, 1, 0, 0, 24, 1, 1, 16);
    tbl[22] = mk(0, 0, 1, 0, 0, 24, 1, 0, 16);
    tbl[23] = mk(0, 0, 0, 1, 0, 24, 1, 0, 16);
    tbl[24] = mk(0, 0, 0, 1, 0, 24, 1, 0, 16);
    tbl[25] = mk(0, 0, 0, 1, 0, 24, 0, 0, 15);
    tbl[26] = mk(0, 1, 0, 1, 1, 25, 1, 0, 16);

    wrst = 1; winc = 0; woverflow_clr = 0; rptr = '0;
    for (int i = 0; i < 27; i++) begin
      t = tbl[i];
      wrst = t.rst; winc = t.inc; woverflow_clr = t.clr; rptr = t.rp;
      #1;
      chk($sformatf("tbl%0d wclken", i), int'(wclken), int'(t.inc));
      tick();
      chk($sformatf("tbl%0d waddr", i), int'(waddr), int'(t.addr));
      chk($sformatf("tbl%0d wptr", i), int'(wptr), int'(t.ptr));
      chk($sformatf("tbl%0d wfull", i), int'(wfull), int'(t.full));
      chk($sformatf("tbl%0d woverflow", i), int'(woverflow), int'(t.ovf));
      chk_status($sformatf("tbl%0d", i), int'(t.lvl), t.af);
    end

    // Wrap: 40 writes with the reader trailing 4 writes behind.
    wrst = 1; winc = 0; woverflow_clr = 0; rptr = '0;
    tick(); tick();
    wrst = 0;
    for (int n = 0; n < 40; n++) begin
      winc = 1;
      rptr = (n >= 4) ? hist[n-4] : '0;
      prev = wptr;
      tick();
      hist[n] = wptr;
      chk($sformatf("wrap%0d onebit", n), $countones(wptr ^ prev), 1);
      chk($sformatf("wrap%0d wptr", n), int'(wptr), int'(gray(n + 1)));
      chk($sformatf("wrap%0d wfull", n), int'(wfull), 0);
    end
    winc = 0;

    // Randomized traffic with reader speed varying per segment.
    wrst = 1; woverflow_clr = 0; rptr = '0;
    tick();
    model_step(1, 0, 0, '0);
    wrst = 0;
    rtot = 0;
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 400; c++) begin
        winc = ($urandom_range(0, 3) != 0);
        woverflow_clr = ($urandom_range(0, 15) == 0);
        if (($urandom_range(0, 5) < seg + 1) && (rtot < m_wtot)) rtot++;
        rptr = gray(rtot);
        if ($urandom_range(0, 499) == 0) wrst = 1;
        if (wrst) rtot = 0;
        tick();
        model_step(wrst, winc, woverflow_clr, rptr);
        if (wrst) begin
          rptr = '0;
          wrst = 0;
        end
        chk("rnd waddr", int'(waddr), m_wtot % D);
        chk("rnd wptr", int'(wptr), int'(gray(m_wtot)));
        chk("rnd wfull", int'(wfull), int'(m_full));
        chk("rnd woverflow", int'(woverflow), int'(m_ovf));
        chk_status("rnd", m_lvl, m_lvl >= AF);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
